// File: rtl/dct_pkg.sv
// Shared constants, FSM state type and rounding helper for the 8x8 DCT accumulator.
package dct_pkg;

    localparam int PIX_W  = 8;
    localparam int COEF_W = 16;
    localparam int FRAC   = 30;
    localparam int ACC_W  = 47;
    localparam int COS_W  = 32;
    localparam int IDX_W  = 6;

    localparam logic [IDX_W-1:0] LAST_IDX = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_OUT,
        ST_DONE
    } state_t;

    // Half an output LSB at the accumulator scale, one bit wider than the accumulator
    function automatic logic signed [ACC_W:0] round_const(input int frac);
        logic signed [ACC_W:0] r;
        r = '0;
        r[frac-1] = 1'b1;
        return r;
    endfunction

    localparam logic signed [ACC_W:0] ROUND_C = round_const(FRAC);

endpackage

// File: rtl/dct_mac.sv
// Multiply-accumulate datapath: registers the cosine product, multiplies it by the
// level-shifted pixel, accumulates, and produces the rounded/saturated coefficient.
module dct_mac #(
    parameter int PIX_W  = dct_pkg::PIX_W,
    parameter int COEF_W = dct_pkg::COEF_W,
    parameter int FRAC   = dct_pkg::FRAC
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr,
    input  logic                             en,
    input  logic [PIX_W-1:0]                 pix_data,
    input  logic signed [dct_pkg::COS_W-1:0] cos_term,
    output logic signed [COEF_W-1:0]         coef_data
);
    import dct_pkg::*;

    localparam int DIFF_W = PIX_W + 1;
    localparam int PROD_W = DIFF_W + COS_W;
    localparam int TOP_W  = ACC_W - COEF_W + 2;

    localparam logic signed [DIFF_W-1:0] PIX_OFS = {2'b01, {(PIX_W-1){1'b0}}};
    localparam logic signed [ACC_W:0]    RND     = round_const(FRAC);

    logic signed [COS_W-1:0]  cos_q, cos_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DIFF_W-1:0] pix_diff;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W:0]    acc_rnd;
    logic signed [ACC_W:0]    acc_shr;
    logic [TOP_W-1:0]         top_bits;

    // The cosine term is captured when its address issues so it lines up with the
    // synchronous pixel read one cycle later.
    always_comb begin
        cos_d    = cos_term;
        pix_diff = $signed({1'b0, pix_data}) - PIX_OFS;
        prod     = PROD_W'(pix_diff) * PROD_W'(cos_q);
        acc_d    = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + ACC_W'(prod);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cos_q <= '0;
            acc_q <= '0;
        end else begin
            cos_q <= cos_d;
            acc_q <= acc_d;
        end
    end

    // Round half-up at the Q.FRAC point, then clamp to the signed coefficient range
    always_comb begin
        acc_rnd  = {acc_q[ACC_W-1], acc_q} + RND;
        acc_shr  = acc_rnd >>> FRAC;
        top_bits = acc_shr[ACC_W:COEF_W-1];
        if ((&top_bits) || !(|top_bits)) begin
            coef_data = acc_shr[COEF_W-1:0];
        end else if (acc_shr[ACC_W]) begin
            coef_data = {1'b1, {(COEF_W-1){1'b0}}};
        end else begin
            coef_data = {1'b0, {(COEF_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/dct_accumulator.sv
// 8x8 forward DCT by brute-force accumulation: for each output index k the block
// walks all 64 pixels n, accumulating (pixel-offset) * cos_term(k,n), then emits
// one coefficient through a valid/ready handshake.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | waiting for start; address/index outputs hold
//   ST_RUN   | issuing term n = 0..63 for the current k
//   ST_DRAIN | one cycle for the final MAC of term 63
//   ST_OUT   | coefficient valid, waiting for coef_ready
//   ST_DONE  | one-cycle done pulse, then back to idle
module dct_accumulator #(
    parameter int PIX_W  = dct_pkg::PIX_W,
    parameter int COEF_W = dct_pkg::COEF_W,
    parameter int FRAC   = dct_pkg::FRAC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [5:0]               pix_addr,
    input  logic [PIX_W-1:0]         pix_data,
    output logic [2:0]               k1,
    output logic [2:0]               k2,
    output logic [2:0]               n1,
    output logic [2:0]               n2,
    input  logic signed [31:0]       cos_term,
    output logic                     coef_valid,
    input  logic                     coef_ready,
    output logic signed [COEF_W-1:0] coef_data,
    output logic [5:0]               coef_idx
);
    import dct_pkg::*;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic             mac_en_q, mac_en_d;
    logic             mac_clr;

    // Next-state, term/coefficient counters and accumulator clear
    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        k_d      = k_q;
        mac_clr  = 1'b0;
        mac_en_d = (state_q == ST_RUN);
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    n_d     = '0;
                    k_d     = '0;
                    mac_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (n_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                end else begin
                    n_d = n_q + 6'd1;
                end
            end
            ST_DRAIN: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (coef_ready) begin
                    if (k_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                        n_d     = '0;
                        k_d     = k_q + 6'd1;
                        mac_clr = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            k_q      <= '0;
            mac_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            k_q      <= k_d;
            mac_en_q <= mac_en_d;
        end
    end

    // Outputs decoded from registered state; k only advances on a transfer, so
    // coef_idx and the coefficient are stable while stalled in ST_OUT.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        coef_valid = (state_q == ST_OUT);
        pix_addr   = n_q;
        n1         = n_q[5:3];
        n2         = n_q[2:0];
        k1         = k_q[5:3];
        k2         = k_q[2:0];
        coef_idx   = k_q;
    end

    dct_mac #(
        .PIX_W  (PIX_W),
        .COEF_W (COEF_W),
        .FRAC   (FRAC)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (mac_clr),
        .en        (mac_en_q),
        .pix_data  (pix_data),
        .cos_term  (cos_term),
        .coef_data (coef_data)
    );

endmodule

// File: tb/tb_dct_accumulator.sv
// Directed-plus-random bench for dct_accumulator. The bench supplies the pixel
// memory and the cosine LUT, and checks every coefficient against a floating-point
// 2-D DCT of the same block.
module tb_dct_accumulator;

    localparam real PI = 3.14159265358979323846;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic               start = 1'b0;
    logic               coef_ready = 1'b1;
    logic               busy, done, coef_valid;
    logic [5:0]         pix_addr, coef_idx;
    logic [7:0]         pix_data;
    logic [2:0]         k1, k2, n1, n2;
    logic signed [31:0] cos_term;
    logic signed [15:0] coef_data;

    int checks = 0;
    int failures = 0;

    logic [7:0] mem [64];
    int         lut [4096];
    int         exp_coef [64];

    dct_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .pix_addr   (pix_addr),
        .pix_data   (pix_data),
        .k1         (k1),
        .k2         (k2),
        .n1         (n1),
        .n2         (n2),
        .cos_term   (cos_term),
        .coef_valid (coef_valid),
        .coef_ready (coef_ready),
        .coef_data  (coef_data),
        .coef_idx   (coef_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pix_data <= mem[pix_addr];

    always_comb cos_term = lut[{k1, k2, n1, n2}];

    function automatic real basis(input int k, input int n);
        real a;
        a = (k == 0) ? $sqrt(0.125) : 0.5;
        return a * $cos(real'((2 * n + 1) * k) * PI / 16.0);
    endfunction

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    task automatic build_model();
        real s;
        int  v;
        for (int k = 0; k < 64; k++) begin
            s = 0.0;
            for (int n = 0; n < 64; n++)
                s += real'(int'(mem[n]) - 128) * basis(k / 8, n / 8) * basis(k % 8, n % 8);
            v = rnd(s);
            if (v > 32767) v = 32767;
            if (v < -32768) v = -32768;
            exp_coef[k] = v;
        end
    endtask

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_near(input string tag, input logic signed [15:0] obs, input int exp, input int tol);
        checks++;
        assert (!$isunknown(obs) && int'(obs) >= exp - tol && int'(obs) <= exp + tol) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d tol=%0d", tag, obs, exp, tol);
        end
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < 64; i++) mem[i] = v;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
    endtask

    // One full transform. stall_idx >= 0 holds coef_ready low 10 cycles at that index;
    // stray_idx >= 0 pulses start mid-RUN of that index; abort_idx >= 0 asserts reset
    // when that index reaches term abort_term.
    task automatic run_block(input string name, input int tol, input int stall_idx,
                             input int stray_idx, input int abort_idx, input int abort_term);
        int                 cyc, next_idx, busy_cycles, stall_cnt, done_cyc, exp_done;
        logic signed [15:0] held_data;
        logic [5:0]         held_idx;
        bit                 stray_sent, aborted;
        build_model();
        next_idx    = 0;
        busy_cycles = 0;
        stall_cnt   = 0;
        done_cyc    = -1;
        stray_sent  = 1'b0;
        aborted     = 1'b0;
        held_data   = '0;
        held_idx    = '0;
        exp_done    = 4225 + ((stall_idx >= 0) ? 10 : 0);
        coef_ready  = 1'b1;

        @(negedge clk);
        chk({name, ":idle_before_start"}, busy, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 4400 && done_cyc < 0) begin
            if (busy) busy_cycles++;
            if (abort_idx >= 0 && busy && !coef_valid &&
                {k1, k2} == abort_idx[5:0] && pix_addr == abort_term[5:0]) begin
                rst_n = 1'b0;
                #1;
                chk({name, ":reset_outputs"},
                    {busy, done, coef_valid, coef_data, coef_idx, pix_addr, k1, k2, n1, n2}, 0);
                aborted = 1'b1;
                break;
            end
            start = (stray_idx >= 0 && !stray_sent && busy && !coef_valid &&
                     {k1, k2} == stray_idx[5:0] && pix_addr == 6'd10);
            if (start) stray_sent = 1'b1;
            coef_ready = 1'b1;
            if (coef_valid) begin
                if (next_idx == stall_idx && stall_cnt < 10) begin
                    if (stall_cnt == 0) begin
                        held_data = coef_data;
                        held_idx  = coef_idx;
                    end else begin
                        chk({name, ":stall_data_stable"}, coef_data, held_data);
                        chk({name, ":stall_idx_stable"}, coef_idx, held_idx);
                    end
                    stall_cnt++;
                    coef_ready = 1'b0;
                end else begin
                    if (next_idx == stall_idx) begin
                        chk({name, ":stall_data_at_xfer"}, coef_data, held_data);
                    end
                    chk({name, ":coef_idx"}, coef_idx, next_idx);
                    chk_near({name, ":coef_data"}, coef_data, exp_coef[next_idx % 64], tol);
                    next_idx++;
                end
            end
            if (done) done_cyc = cyc;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        coef_ready = 1'b1;

        if (abort_idx >= 0) begin
            chk({name, ":abort_reached"}, aborted, 1);
        end else begin
            chk({name, ":done_cycle"}, done_cyc, exp_done);
            chk({name, ":busy_cycles"}, busy_cycles, exp_done);
            chk({name, ":coef_count"}, next_idx, 64);
            chk({name, ":idle_after_done"}, {busy, done, coef_valid}, 0);
            if (stall_idx >= 0) chk({name, ":stall_cycles"}, stall_cnt, 10);
            if (stray_idx >= 0) chk({name, ":stray_start_sent"}, stray_sent, 1);
        end
    endtask

    initial begin
        int seen;
        for (int i = 0; i < 4096; i++) begin
            lut[i] = rnd(basis(i / 512, (i / 8) % 8) * basis((i / 64) % 8, i % 8) * 1073741824.0);
        end
        fill_const(8'd128);

        #1 rst_n = 1'b0;
        #1;
        chk("reset_state",
            {busy, done, coef_valid, coef_data, coef_idx, pix_addr, k1, k2, n1, n2}, 0);
        chk("lut_dc_entry", lut[0], 32'h0800_0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        fill_const(8'd128);
        run_block("flat128", 0, -1, -1, -1, 0);
        fill_const(8'd255);
        run_block("flat255", 0, -1, -1, -1, 0);
        fill_const(8'd0);
        run_block("flat0", 0, -1, -1, -1, 0);

        fill_random();
        run_block("stall_idx5", 1, 5, -1, -1, 0);
        fill_random();
        run_block("stray_start_idx20", 1, -1, 20, -1, 0);
        fill_random();
        run_block("abort_idx30", 1, -1, -1, 30, 17);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (200) begin
            @(negedge clk);
            if (coef_valid || busy || done) seen++;
        end
        chk("quiet_after_reset", seen, 0);

        fill_random();
        run_block("random_after_reset", 1, -1, -1, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
